// File: rtl/instr_issue_pkg.sv
// Shared types for the instruction issue stage: FSM states, default PC
// step and the {pc, word} record buffered between fetch and execute.
package instr_issue_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } issue_state_t;

   localparam int PC_STEP_DEFAULT = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fifo_entry_t;

endpackage

// File: rtl/issue_fifo.sv
// Small circular buffer of fetched {pc, word} entries with a synchronous
// flush and a combinational head read.
module issue_fifo
   import instr_issue_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         push,
   input  logic                         pop,
   input  logic [$bits(fifo_entry_t)-1:0] wdata,
   output logic [$bits(fifo_entry_t)-1:0] rdata,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int EW = $bits(fifo_entry_t);

   logic [EW-1:0] mem [DEPTH];
   logic [PW-1:0] rdPtr;
   logic [PW-1:0] wrPtr;

   // Storage is cleared on reset so the head reads as zero until the first push;
   // a flush only rewinds the pointers and leaves stale data behind the empty head.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wrPtr] <= wdata;
            wrPtr      <= wrPtr + PW'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + PW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rdPtr];

endmodule

// File: rtl/instr_issue.sv
// Fetch/issue front end: owns the fetch PC, keeps one instruction-memory
// request outstanding and hands buffered words to execute via valid/ready.
module instr_issue
   import instr_issue_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = PC_STEP_DEFAULT
) (
   input  logic                       clk,
   input  logic                       reset,
   output logic                       imem_req,
   output logic [31:0]                imem_addr,
   input  logic                       imem_ack,
   input  logic [31:0]                imem_rdata,
   output logic                       ins_valid,
   output logic [31:0]                ins,
   output logic [31:0]                ins_pc,
   input  logic                       ins_ready,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam logic [31:0] DEPTH_W = 32'(DEPTH);
   localparam logic [31:0] STEP_W  = 32'(PC_STEP);

   issue_state_t state;
   issue_state_t nextState;
   logic [31:0]  pc;
   logic [31:0]  nextPc;
   logic [31:0]  reqAddr;
   logic [31:0]  nextReqAddr;
   logic [31:0]  pcInc;
   logic [31:0]  occAfterPush;
   logic         push;
   logic         pop;
   fifo_entry_t  pushEntry;
   fifo_entry_t  headEntry;

   // State, fetch PC and outstanding request address
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         reqAddr <= RESET_PC;
      end else begin
         state   <= nextState;
         pc      <= nextPc;
         reqAddr <= nextReqAddr;
      end
   end

   assign pcInc        = pc + STEP_W;
   assign occAfterPush = 32'(count) + 32'd1 - 32'(pop);
   assign pop          = ins_valid & ins_ready & ~redirect;
   assign push         = (state == WAIT) & imem_ack & ~redirect;

   // Next-state logic; a redirect always wins over issuing or accepting data,
   // and an abandoned request is still carried through DROP until memory acks it
   always_comb begin
      nextState   = state;
      nextPc      = pc;
      nextReqAddr = reqAddr;
      unique case (state)
         IDLE: begin
            if (redirect) begin
               nextPc = redirect_pc;
            end else if (32'(count) < DEPTH_W) begin
               nextReqAddr = pc;
               nextState   = WAIT;
            end
         end
         WAIT: begin
            if (redirect) begin
               nextPc    = redirect_pc;
               nextState = imem_ack ? IDLE : DROP;
            end else if (imem_ack) begin
               nextPc = pcInc;
               if (occAfterPush < DEPTH_W) begin
                  nextReqAddr = pcInc;
               end else begin
                  nextState = IDLE;
               end
            end
         end
         DROP: begin
            if (redirect) begin
               nextPc = redirect_pc;
            end
            if (imem_ack) begin
               nextState = IDLE;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   assign pushEntry.pc   = reqAddr;
   assign pushEntry.word = imem_rdata;

   issue_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (redirect),
      .push  (push),
      .pop   (pop),
      .wdata (pushEntry),
      .rdata (headEntry),
      .count (count)
   );

   assign imem_req  = (state == WAIT) || (state == DROP);
   assign imem_addr = reqAddr;
   assign ins_valid = (count != '0);
   assign ins       = headEntry.word;
   assign ins_pc    = headEntry.pc;

endmodule
